// File: rtl/oam_dma.sv
// oam_dma: OAM DMA engine; copies 160 bytes from {FF46,8'h00} (E0-FF mirrored to C0-DF) into OAM FE00-FE9F.
// Latency: first src_rd SETUP_CYCLES+1 cycles after the FF46 write edge, then one byte per CYCLES_PER_BYTE cycles.
// Backpressure: none; the OAM mux and CPU bus arbiter must yield to this block while dma_active is high.
// Ports: mmio_a/mmio_din/mmio_wr/mmio_dout - CPU access to FF46 (mmio_dout combinational, 8'h00 unless reading FF46)
//        src_a/src_rd/src_dout - source read port, data valid one cycle after src_rd
//        oam_a/oam_din/oam_wr - OAM write port; dma_active - transfer in progress (setup + copy)
module oam_dma #(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int SETUP_CYCLES    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] mmio_a,
   input  logic [7:0]  mmio_din,
   input  logic        mmio_wr,
   output logic [7:0]  mmio_dout,
   output logic [15:0] src_a,
   output logic        src_rd,
   input  logic [7:0]  src_dout,
   output logic [15:0] oam_a,
   output logic [7:0]  oam_din,
   output logic        oam_wr,
   output logic        dma_active
);

   localparam logic [7:0] LAST_IDX   = 8'd159;
   localparam logic [7:0] LAST_SLOT  = 8'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0] LAST_SETUP = 8'(SETUP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_COPY
   } state_t;

   state_t      r_state;
   logic [7:0]  r_dma_q;
   logic [7:0]  r_src_hi;
   logic [7:0]  r_idx;
   logic [7:0]  r_slot;
   logic [7:0]  r_cnt;
   logic        r_src_rd;
   logic        r_oam_wr;
   logic        r_active;
   logic [15:0] r_src_a;
   logic [15:0] r_oam_a;
   logic [7:0]  r_oam_din;

   logic        w_ff46_wr;
   logic [7:0]  w_src_hi;

   assign w_ff46_wr = mmio_wr && (mmio_a == 16'hFF46);
   // E0-FF source pages alias WRAM C0-DF; only the copy address is remapped, not dma_q
   assign w_src_hi  = (mmio_din < 8'hE0) ? mmio_din : (mmio_din - 8'h20);

   assign mmio_dout  = (!mmio_wr && (mmio_a == 16'hFF46)) ? r_dma_q : 8'h00;
   assign src_a      = r_src_a;
   assign src_rd     = r_src_rd;
   assign oam_a      = r_oam_a;
   assign oam_din    = r_oam_din;
   assign oam_wr     = r_oam_wr;
   assign dma_active = r_active;

   // State/slot registers describe the current cycle; strobes are registered one edge
   // ahead so that each strobe is high during the slot it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_dma_q   <= 8'h00;
         r_src_hi  <= 8'h00;
         r_idx     <= 8'h00;
         r_slot    <= 8'h00;
         r_cnt     <= 8'h00;
         r_src_rd  <= 1'b0;
         r_oam_wr  <= 1'b0;
         r_active  <= 1'b0;
         r_src_a   <= 16'h0000;
         r_oam_a   <= 16'h0000;
         r_oam_din <= 8'h00;
      end else begin
         r_src_rd <= 1'b0;
         r_oam_wr <= 1'b0;
         if (w_ff46_wr) begin
            // (Re)start wins over any strobe the old transfer had scheduled
            r_dma_q  <= mmio_din;
            r_src_hi <= w_src_hi;
            r_state  <= ST_SETUP;
            r_cnt    <= 8'h00;
            r_idx    <= 8'h00;
            r_slot   <= 8'h00;
            r_active <= 1'b1;
         end else begin
            case (r_state)
               ST_SETUP: begin
                  if (r_cnt == LAST_SETUP) begin
                     r_state  <= ST_COPY;
                     r_idx    <= 8'h00;
                     r_slot   <= 8'h00;
                     r_src_rd <= 1'b1;
                     r_src_a  <= {r_src_hi, 8'h00};
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               ST_COPY: begin
                  // Slot 1: source data is on src_dout; the oam_din register doubles as the data latch
                  if (r_slot == 8'd1) begin
                     r_oam_din <= src_dout;
                     r_oam_wr  <= 1'b1;
                     r_oam_a   <= 16'hFE00 + {8'h00, r_idx};
                  end
                  if (r_slot == LAST_SLOT) begin
                     r_slot <= 8'h00;
                     if (r_idx == LAST_IDX) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                     end else begin
                        r_idx    <= r_idx + 8'd1;
                        r_src_rd <= 1'b1;
                        r_src_a  <= {r_src_hi, r_idx + 8'd1};
                     end
                  end else begin
                     r_slot <= r_slot + 8'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine for the GameMan DMG core. A CPU write to 0xFF46 starts a 160-byte copy from `{FF46,8'h00}` into OAM (0xFE00–0xFE9F). The block sits upstream of the PPU's OAM port. While `dma_active` is high, the top-level OAM mux gives this block priority over PPU mode 2/3 accesses and the CPU bus arbiter blocks non-HRAM accesses. The block owns the 0xFF46 MMIO register.

## Interface
Parameters:
- `CYCLES_PER_BYTE`, 4: clocks per transferred byte; legal range ≥3.
- `SETUP_CYCLES`, 4: delay between the 0xFF46 write and the first source read.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mmio_a` in 16: CPU MMIO address.
- `mmio_din` in 8: CPU write data.
- `mmio_wr` in 1: CPU write strobe, one cycle.
- `mmio_dout` out 8: read data. Equals the DMA register when `mmio_a`==16'hFF46 and `!mmio_wr`; otherwise 8'h00, so the top can OR it with other sources.
- `src_a` out 16: source memory address.
- `src_rd` out 1: source read strobe; `src_dout` is valid exactly one cycle later.
- `src_dout` in 8: source read data.
- `oam_a` out 16: OAM write address.
- `oam_din` out 8: OAM write data.
- `oam_wr` out 1: OAM write strobe, one cycle per byte.
- `dma_active` out 1: transfer in progress, covering the SETUP and COPY states.

## Operation
- Register `dma_q[7:0]`, reset 8'h00. Any write to 16'hFF46 loads `mmio_din` into `dma_q` and (re)starts a transfer.
- Source high byte `src_hi`:
  - `mmio_din` when `mmio_din` < 8'hE0;
  - `mmio_din` − 8'h20 otherwise, so 0xE0–0xFF mirror WRAM 0xC0–0xDF.
  - `dma_q` always stores the raw written value.
- State machine:
  - IDLE → SETUP on an FF46 write.
  - SETUP: count `SETUP_CYCLES`, then go to COPY with `idx`=0 and `slot`=0.
  - COPY: per byte, `slot` counts from 0 to `CYCLES_PER_BYTE`−1.
    - `slot` 0: `src_rd`=1, `src_a`={`src_hi`,`idx`}.
    - `slot` 1: latch `src_dout` into `data_q`.
    - `slot` 2: `oam_wr`=1, `oam_a`=16'hFE00+`idx`, `oam_din`=`data_q`.
    - `slot` ≥3: idle.
    - At `slot`=`CYCLES_PER_BYTE`−1: if `idx`==159 go to IDLE, else `idx`+1 and `slot` 0.
- `idx` is 8 bits and never exceeds 159. `src_a` low byte = `idx`. OAM addresses never exceed 0xFE9F.
- Restart: an FF46 write in SETUP or COPY aborts the current transfer with no further strobe for the old source. The engine re-enters SETUP with the new source, `idx`=0, and `dma_active` stays high throughout.
  - If the restart lands in the same cycle as a scheduled `oam_wr`, the write is suppressed.
- `src_rd` and `oam_wr` are 0 in IDLE and SETUP. `src_a`, `oam_a` and `oam_din` hold their last value when their strobe is low.
- Asynchronous reset mid-transfer: immediately returns to IDLE and clears all outputs; OAM is left partially written.
- Writes to other MMIO addresses are ignored.

## Timing
- Reset values:
  - `dma_active`=0, `src_rd`=0, `oam_wr`=0;
  - `src_a`=16'h0000, `oam_a`=16'h0000, `oam_din`=8'h00;
  - `dma_q`=8'h00.
  - `mmio_dout` follows `dma_q` combinationally.
- The FF46 write is sampled at edge E0. `dma_active` rises after E0.
- First `src_rd` in cycle E0+`SETUP_CYCLES`+1. The first `oam_wr` follows 2 cycles later.
- Byte n: `src_rd` at cycle E0+`SETUP_CYCLES`+1+n·`CYCLES_PER_BYTE`.
- With defaults:
  - `dma_active` is high for exactly 4+160·4 = 644 cycles;
  - the last `oam_wr` (to 0xFE9F) is 2 cycles before `dma_active` falls.
- Exactly 160 `src_rd` and 160 `oam_wr` pulses per uninterrupted transfer. All outputs are registered.
- `mmio_dout` is combinational (zero-latency read), matching the PPU MMIO reads.

## Test plan
- Reset then idle: `rst_n` low mid-cycle → all outputs 0 asynchronously; reading FF46 returns 8'h00; no strobes for 1000 cycles.
- Basic copy: source model returns `addr[7:0]^8'h5A`; write FF46=8'hC1 → 644 active cycles, `src_a` sweeps 0xC100–0xC19F, `oam_wr` writes 0xFE00..0xFE9F with matching data, 160 pulses each, FF46 reads 8'hC1.
- Echo mapping: write FF46=8'hE3 → `src_a` 0xC300–0xC39F; FF46 readback 8'hE3.
- Restart: write FF46=8'h80, then FF46=8'h90 after byte 50's `src_rd`. Required:
  - no further 0x80xx reads;
  - the new transfer starts at 0x9000 / 0xFE00;
  - `dma_active` never drops;
  - 644 active cycles counted from the second write.
- Reset mid-copy: assert `rst_n` at byte 80 → `dma_active`=0 and `oam_wr`=0 immediately; after release, no activity until the next FF46 write.
- Parameter sweep `CYCLES_PER_BYTE`=3, `SETUP_CYCLES`=1 → 481 active cycles, data correct; `mmio_dout`=0 for reads of 0xFF45/0xFF47.
